// File: rtl/tmds_gearbox.sv
// Symbol-to-slice gearbox for the TMDS serialiser path: splits each CHANNELS-wide
// group of 10-bit symbols into RATIO slices, substituting idle symbols on underflow.
module tmds_gearbox #(
  parameter int                     CHANNELS        = 4,
  parameter int                     SLICE_WIDTH     = 5,
  parameter bit                     MSB_SLICE_FIRST = 1'b1,
  parameter logic [CHANNELS*10-1:0] IDLE_SYMBOLS    = {10'b1111100000, {3{10'b1101010100}}}
) (
  input  logic                            clock,
  input  logic                            resetN,
  input  logic [CHANNELS*10-1:0]          symbolData,
  input  logic                            symbolValid,
  output logic                            symbolReady,
  input  logic                            slip,
  input  logic                            clearCount,
  output logic [CHANNELS*SLICE_WIDTH-1:0] sliceData,
  output logic                            symbolStart,
  output logic                            underflow,
  output logic [15:0]                     underflowCount
);

  localparam int            RATIO = 10 / SLICE_WIDTH;
  localparam int            PW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [PW-1:0] LAST  = PW'(RATIO - 1);

  logic [PW-1:0]                   phase_q, phase_d;
  logic [CHANNELS*10-1:0]          hold_q, hold_d;
  logic [CHANNELS*SLICE_WIDTH-1:0] slice_q, slice_d;
  logic                            start_q, start_d;
  logic                            uf_q, uf_d;
  logic [15:0]                     count_q, count_d;

  // Extract slice idx of every channel in a symbol group, honouring slice order.
  function automatic logic [CHANNELS*SLICE_WIDTH-1:0] pick_slice(
    input logic [CHANNELS*10-1:0] grp,
    input logic [PW-1:0]          idx
  );
    logic [CHANNELS*SLICE_WIDTH-1:0] r;
    logic [9:0]                      sym;
    int                              lo;
    r = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      sym = grp[c*10 +: 10];
      lo  = MSB_SLICE_FIRST ? (10 - SLICE_WIDTH * (int'(idx) + 1)) : (SLICE_WIDTH * int'(idx));
      r[c*SLICE_WIDTH +: SLICE_WIDTH] = SLICE_WIDTH'(sym >> lo);
    end
    return r;
  endfunction

  assign symbolReady = resetN & ~slip & (phase_q == LAST);

  // NOTE: every signal gets a default first so no path leaves a value unassigned (no latches).
  always_comb begin
    phase_d = phase_q;
    hold_d  = hold_q;
    slice_d = slice_q;
    start_d = 1'b0;
    uf_d    = 1'b0;
    count_d = count_q;
    if (!slip) begin
      if (phase_q == LAST) begin
        phase_d = '0;
        start_d = 1'b1;
        if (symbolValid) begin
          hold_d = symbolData;
        end else begin
          hold_d = IDLE_SYMBOLS;
          uf_d   = 1'b1;
          if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
        end
        slice_d = pick_slice(hold_d, '0);
      end else begin
        phase_d = phase_q + 1'b1;
        slice_d = pick_slice(hold_q, phase_d);
      end
    end
    // Clear wins over a coincident underflow increment.
    if (clearCount) count_d = '0;
  end

  // NOTE: state updates use non-blocking assignments; reset is synchronous, sampled on the edge.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      phase_q <= LAST;
      hold_q  <= IDLE_SYMBOLS;
      slice_q <= '0;
      start_q <= 1'b0;
      uf_q    <= 1'b0;
      count_q <= '0;
    end else begin
      phase_q <= phase_d;
      hold_q  <= hold_d;
      slice_q <= slice_d;
      start_q <= start_d;
      uf_q    <= uf_d;
      count_q <= count_d;
    end
  end

  assign sliceData      = slice_q;
  assign symbolStart    = start_q;
  assign underflow      = uf_q;
  assign underflowCount = count_q;

endmodule

// File: tb/tb_tmds_gearbox.sv
// Bench for tmds_gearbox: default 4x5-bit MSB-first build driven against a slice-level
// model, plus 2-bit LSB-first and 10-bit builds for the parameter corners and counter.
module tb_tmds_gearbox;

  localparam logic [39:0] IDLE4 = {10'b1111100000, {3{10'b1101010100}}};
  localparam logic [9:0]  IDLE1 = 10'b1101010100;

  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic resetN;

  // default build
  logic [39:0] sym_m;
  logic        val_m, rdy_m, slip_m, clr_m, st_m, uf_m;
  logic [19:0] slc_m;
  logic [15:0] cnt_m;
  // 2-bit, LSB-first build
  logic [9:0]  sym_2;
  logic        val_2, rdy_2, st_2, uf_2;
  logic [1:0]  slc_2;
  logic [15:0] cnt_2;
  // 10-bit build
  logic [39:0] sym_10, slc_10;
  logic        val_10, rdy_10, slip_10, clr_10, st_10, uf_10;
  logic [15:0] cnt_10;

  tmds_gearbox #(.CHANNELS(4), .SLICE_WIDTH(5), .MSB_SLICE_FIRST(1'b1), .IDLE_SYMBOLS(IDLE4)) u_main (
    .clock(clock), .resetN(resetN), .symbolData(sym_m), .symbolValid(val_m), .symbolReady(rdy_m),
    .slip(slip_m), .clearCount(clr_m), .sliceData(slc_m), .symbolStart(st_m), .underflow(uf_m),
    .underflowCount(cnt_m));

  tmds_gearbox #(.CHANNELS(1), .SLICE_WIDTH(2), .MSB_SLICE_FIRST(1'b0), .IDLE_SYMBOLS(IDLE1)) u_w2 (
    .clock(clock), .resetN(resetN), .symbolData(sym_2), .symbolValid(val_2), .symbolReady(rdy_2),
    .slip(1'b0), .clearCount(1'b0), .sliceData(slc_2), .symbolStart(st_2), .underflow(uf_2),
    .underflowCount(cnt_2));

  tmds_gearbox #(.CHANNELS(4), .SLICE_WIDTH(10), .MSB_SLICE_FIRST(1'b1), .IDLE_SYMBOLS(IDLE4)) u_w10 (
    .clock(clock), .resetN(resetN), .symbolData(sym_10), .symbolValid(val_10), .symbolReady(rdy_10),
    .slip(slip_10), .clearCount(clr_10), .sliceData(slc_10), .symbolStart(st_10), .underflow(uf_10),
    .underflowCount(cnt_10));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model of the default build: which slice index is showing, and of which group.
  int          m_phase;
  logic [39:0] m_hold;
  logic [19:0] m_slice;
  logic        m_start, m_uf;
  int          m_cnt;

  // Slice k (0 = first out) of each 10-bit symbol, high bits first, 5 bits per slice.
  function automatic logic [19:0] model_slice(input logic [39:0] grp, input int k);
    logic [19:0] r;
    logic [9:0]  s;
    r = '0;
    for (int ch = 0; ch < 4; ch++) begin
      s = grp[ch*10 +: 10];
      r[ch*5 +: 5] = 5'((s >> (5 - 5 * k)) % 32);
    end
    return r;
  endfunction

  // One cycle of the default build: drive, check at the falling edge, advance the model.
  task automatic main_cycle(input logic v, input logic [39:0] d, input logic s, input logic c);
    logic exp_rdy;
    val_m = v; sym_m = d; slip_m = s; clr_m = c;
    @(negedge clock);
    exp_rdy = !s && (m_phase == 1);
    n_checks++; if (rdy_m !== exp_rdy) begin n_fail++; $display("FAIL ready: got %b want %b", rdy_m, exp_rdy); end
    n_checks++; if (slc_m !== m_slice) begin n_fail++; $display("FAIL slice: got %h want %h", slc_m, m_slice); end
    n_checks++; if (st_m !== m_start) begin n_fail++; $display("FAIL start: got %b want %b", st_m, m_start); end
    n_checks++; if (uf_m !== m_uf) begin n_fail++; $display("FAIL underflow: got %b want %b", uf_m, m_uf); end
    n_checks++; if (cnt_m !== 16'(m_cnt)) begin n_fail++; $display("FAIL count: got %0d want %0d", cnt_m, m_cnt); end
    m_start = 1'b0;
    m_uf    = 1'b0;
    if (!s) begin
      if (m_phase == 1) begin
        m_hold  = v ? d : IDLE4;
        m_phase = 0;
        m_start = 1'b1;
        m_uf    = !v;
        if (!v && m_cnt < 65535) m_cnt++;
      end else begin
        m_phase++;
      end
      m_slice = model_slice(m_hold, m_phase);
    end
    if (c) m_cnt = 0;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    val_m = 1'b0; sym_m = '0; slip_m = 1'b0; clr_m = 1'b0;
    val_2 = 1'b0; sym_2 = '0;
    val_10 = 1'b1; sym_10 = '0; slip_10 = 1'b0; clr_10 = 1'b0;
    repeat (3) begin
      @(posedge clock); #1;
      n_checks++; if (slc_m !== 20'h0) begin n_fail++; $display("FAIL rst_slice: got %h want 0", slc_m); end
      n_checks++; if ({st_m, uf_m} !== 2'b00) begin n_fail++; $display("FAIL rst_flags: got %b want 00", {st_m, uf_m}); end
      n_checks++; if (cnt_m !== 16'h0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", cnt_m); end
      n_checks++; if ({rdy_m, rdy_2, rdy_10} !== 3'b000) begin n_fail++; $display("FAIL rst_ready: got %b want 000", {rdy_m, rdy_2, rdy_10}); end
    end
    resetN = 1'b1;
    #1;
    n_checks++; if (rdy_m !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b want 1", rdy_m); end
    m_phase = 1; m_hold = IDLE4; m_slice = '0; m_start = 1'b0; m_uf = 1'b0; m_cnt = 0;
  endtask

  task automatic test_streaming();
    logic [39:0] d;
    d = {20'($urandom), 10'h01F, 10'h3E0};
    for (int i = 0; i < 4; i++) begin
      main_cycle(1'b1, d, 1'b0, 1'b0);
      n_checks++;
      if (slc_m[9:0] !== ((i % 2 == 0) ? 10'b00000_11111 : 10'b11111_00000)) begin
        n_fail++; $display("FAIL stream_ch01 %0d: got %b", i, slc_m[9:0]);
      end
      n_checks++; if (st_m !== (i % 2 == 0)) begin n_fail++; $display("FAIL stream_start %0d: got %b", i, st_m); end
    end
  endtask

  task automatic test_underflow();
    main_cycle(1'b0, 40'h0, 1'b0, 1'b0);
    n_checks++;
    if (slc_m !== {5'b11111, 5'b11010, 5'b11010, 5'b11010}) begin
      n_fail++; $display("FAIL idle_slice0: got %b", slc_m);
    end
    n_checks++; if ({uf_m, cnt_m} !== {1'b1, 16'd1}) begin n_fail++; $display("FAIL idle_flag: got uf=%b cnt=%0d want 1/1", uf_m, cnt_m); end
    main_cycle(1'b1, 40'($urandom), 1'b0, 1'b0);
    n_checks++;
    if ({slc_m, uf_m} !== {5'b00000, 5'b10100, 5'b10100, 5'b10100, 1'b0}) begin
      n_fail++; $display("FAIL idle_slice1: got %b uf=%b", slc_m, uf_m);
    end
  endtask

  task automatic test_slip();
    logic [39:0] d;
    d = {30'($urandom), 10'h3E0};
    main_cycle(1'b1, d, 1'b0, 1'b0);
    main_cycle(1'b1, d, 1'b1, 1'b0);
    n_checks++; if ({slc_m[4:0], st_m} !== {5'h1F, 1'b0}) begin n_fail++; $display("FAIL slip_repeat: got %h/%b want 1f/0", slc_m[4:0], st_m); end
    main_cycle(1'b1, d, 1'b0, 1'b0);
    n_checks++; if (slc_m[4:0] !== 5'h00) begin n_fail++; $display("FAIL slip_slice1: got %h want 00", slc_m[4:0]); end
    main_cycle(1'b1, d, 1'b1, 1'b0);
    n_checks++; if (st_m !== 1'b0) begin n_fail++; $display("FAIL slip_boundary: got %b want 0", st_m); end
    main_cycle(1'b1, d, 1'b0, 1'b0);
    n_checks++; if (st_m !== 1'b1) begin n_fail++; $display("FAIL slip_accept: got %b want 1", st_m); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++)
      main_cycle($urandom_range(0, 9) < 7, {$urandom, 8'($urandom)},
                 $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
  endtask

  task automatic test_width2_lsb_first();
    logic [1:0] exp_sl [5];
    bit found;
    exp_sl = '{2'b11, 2'b01, 2'b10, 2'b00, 2'b11};
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (rdy_2) found = 1'b1;
      else begin @(posedge clock); #1; end
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL w2_ready_timeout: got 0 want 1"); end
    val_2 = 1'b1; sym_2 = 10'b1100100111;
    @(posedge clock); #1;
    val_2 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (slc_2 !== exp_sl[k]) begin n_fail++; $display("FAIL w2_slice%0d: got %b want %b", k, slc_2, exp_sl[k]); end
      n_checks++; if (st_2 !== (k == 0)) begin n_fail++; $display("FAIL w2_start%0d: got %b", k, st_2); end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_width10();
    logic [39:0] d;
    for (int i = 0; i < 8; i++) begin
      d = {$urandom, 8'($urandom)};
      sym_10 = d;
      n_checks++; if (rdy_10 !== 1'b1) begin n_fail++; $display("FAIL w10_ready: got %b want 1", rdy_10); end
      @(posedge clock); #1;
      n_checks++; if ({slc_10, st_10, uf_10} !== {d, 1'b1, 1'b0}) begin n_fail++; $display("FAIL w10_data: got %h want %h", slc_10, d); end
    end
  endtask

  task automatic test_counter();
    n_checks++; if (cnt_10 !== 16'd0) begin n_fail++; $display("FAIL cnt_start: got %0d want 0", cnt_10); end
    val_10 = 1'b0;
    @(posedge clock); #1;
    n_checks++; if ({uf_10, cnt_10} !== {1'b1, 16'd1}) begin n_fail++; $display("FAIL cnt_first: got %b/%0d want 1/1", uf_10, cnt_10); end
    repeat (65536) @(posedge clock);
    #1;
    n_checks++; if (cnt_10 !== 16'hFFFF) begin n_fail++; $display("FAIL cnt_saturate: got %h want ffff", cnt_10); end
    clr_10 = 1'b1;
    @(posedge clock); #1;
    clr_10 = 1'b0;
    n_checks++; if ({uf_10, cnt_10} !== {1'b1, 16'd0}) begin n_fail++; $display("FAIL cnt_clear_priority: got %b/%0d want 1/0", uf_10, cnt_10); end
    val_10 = 1'b1;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_underflow();
    test_slip();
    test_random();
    test_width2_lsb_first();
    test_width10();
    test_counter();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
